fsmlog_seq_det: RTL and testbench
=================================

Name: fsmlog_seq_det

Overview:
- Parametrised serial pattern detector FSM; successor to the fixed 6-state, 1-bit-input sequence FSMs in the fsmlog example set.
- Detects a programmable N-symbol pattern of W-bit symbols on a valid-qualified input stream, with per-symbol don't-care masking and overlap mode.
- Reports each match as a pulse, a sticky flag and a saturating hit count.
- Sits between a serial front end and control logic that consumes match events.

Parameters:
W, 1, symbol width in bits (>=1)
N, 4, pattern length in symbols (1..16)
CNT_W, 8, width of saturating hit counter (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-low
en  input  1  detector enable; 0 forces IDLE
in_vld  input  1  symbol strobe; in_dat accepted when in_vld=1 and en=1
in_dat  input  W  input symbol
pat  input  N*W  pattern; symbol k (k=0 first received) at pat[k*W +: W]
pat_mask  input  N  bit k=1: symbol k is don't-care
overlap  input  1  1: overlapping matches allowed; 0: history restarts after a hit
clr  input  1  synchronous clear of flag and hit_cnt
hit  output  1  one-cycle match pulse
flag  output  1  sticky match indicator
hit_cnt  output  CNT_W  saturating match count
state_o  output  2  current state: 0 IDLE, 1 FILL, 2 SCAN

Behaviour:
- Reset (rst=0, async): state=IDLE, history=0, fill=0, hit=0, flag=0, hit_cnt=0. Takes effect immediately, including mid-pattern. Release is synchronous to clk.
- History: N-entry shift register of accepted symbols. Newest symbol enters position N-1; position 0 holds the oldest of the last N.
- fill: count of accepted symbols since the last restart, saturating at N.
- Accept: acc = en & in_vld.
- Match evaluation on each acc cycle:
  - Window = {history shifted by one, in_dat as newest}.
  - match = acc & (fill+1 >= N) & (for all k: pat_mask[k] | window[k]==pat[k]).
- Latency: hit is registered and asserts exactly 1 cycle after the clock edge that accepts the completing symbol. hit is 0 in every other cycle.
- After a match:
  - overlap=1: fill stays at N.
  - overlap=0: fill resets to 0 and history clears to 0, so the next match needs N fresh symbols.
- Gaps: in_vld=0 cycles hold all state. Gaps between symbols never break a pattern.
- FSM, evaluated per clock:
  - IDLE: en=1 -> FILL.
  - FILL (fill<N): en=0 -> IDLE; fill reaches N without a non-overlap match -> SCAN.
  - SCAN: en=0 -> IDLE; match with overlap=0 -> FILL; otherwise stay.
  - N=1: FILL lasts only until the first accepted symbol.
- en=0: next state IDLE, fill=0, history=0, hit=0 next cycle. flag and hit_cnt are retained.
- flag: set by a registered hit. clr=1 clears it. When clr and a hit register in the same cycle, set wins: flag=1.
- hit_cnt: increments by 1 per hit and saturates at 2^CNT_W-1 (no wrap). clr zeroes it. When clr and a hit coincide, hit_cnt=1.
- pat, pat_mask and overlap are sampled combinationally at each evaluation. A mid-stream change takes effect on the next accepted symbol; history is not flushed.
- All mask bits set: every accepted symbol matches once fill permits.
- Unused state encoding 3 -> IDLE on the next clock.

Test Plan:
- W=1, N=4, pat=4'b1101 (sequence 1,0,1,1), mask=0, overlap=1; stream 1,0,1,1,0,1,1 -> hit one cycle after symbols 4 and 7; hit_cnt=2; flag=1; state_o 1->2 after symbol 4.
- Same stream with overlap=0 -> single hit after symbol 4; state returns to FILL; hit_cnt=1.
- Same pattern with 0-3 idle in_vld=0 cycles between symbols -> identical hit sequence, delayed only by the gaps.
- pat_mask=4'b0010, stream 1,1,1,1 -> hit after symbol 4; with mask=0 -> no hit.
- CNT_W=2, 5 matches, then clr asserted in the same cycle as a 6th hit -> hit_cnt 1,2,3,3,3 then 1; flag stays 1.
- Async rst low mid-pattern (after 3 symbols), then replay 1 symbol -> all outputs 0 immediately; no hit; state FILL. Likewise en low for one cycle mid-pattern -> IDLE, fill restarts, flag retained.

Source files
------------

// File: rtl/fsmlog_seq_det.sv
// rtl/fsmlog_seq_det.sv - programmable N-symbol pattern detector with masking, overlap and hit counting
module fsmlog_seq_det #(
    parameter int W     = 1,
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_vld,
    input  logic [W-1:0]       in_dat,
    input  logic [N*W-1:0]     pat,
    input  logic [N-1:0]       pat_mask,
    input  logic               overlap,
    input  logic               clr,
    output logic               hit,
    output logic               flag,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [1:0]         state_o
);
    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(N);
    localparam logic [FW:0]      N_EXT    = (FW + 1)'(N);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t         state;
    logic [N*W-1:0] hist;
    logic [N*W-1:0] window;
    logic [FW-1:0]  fill;
    logic [FW-1:0]  fill_nxt;
    logic           acc;
    logic           full;
    logic           pat_ok;
    logic           match;
    logic           restart;

    assign acc     = en & in_vld;
    assign full    = ({1'b0, fill} + (FW + 1)'(1)) >= N_EXT;
    assign state_o = state;

    // Candidate window: history aged by one slot with the incoming symbol as newest.
    always_comb begin
        window = hist >> W;
        window[(N-1)*W +: W] = in_dat;
    end

    always_comb begin
        pat_ok = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (!pat_mask[k] && (window[k*W +: W] != pat[k*W +: W])) begin
                pat_ok = 1'b0;
            end
        end
    end

    assign match   = acc & full & pat_ok;
    assign restart = ~en | (match & ~overlap);

    always_comb begin
        fill_nxt = fill;
        if (restart) begin
            fill_nxt = '0;
        end else if (acc && (fill != FILL_MAX)) begin
            fill_nxt = fill + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            hist    <= '0;
            fill    <= '0;
            hit     <= 1'b0;
            flag    <= 1'b0;
            hit_cnt <= '0;
        end else begin
            fill <= fill_nxt;
            hit  <= match;

            if (restart) begin
                hist <= '0;
            end else if (acc) begin
                hist <= window;
            end

            // A hit registering in the same cycle as clr takes priority over the clear.
            if (match) begin
                flag <= 1'b1;
            end else if (clr) begin
                flag <= 1'b0;
            end

            if (match) begin
                if (clr) begin
                    hit_cnt <= CNT_W'(1);
                end else if (hit_cnt != CNT_MAX) begin
                    hit_cnt <= hit_cnt + 1'b1;
                end
            end else if (clr) begin
                hit_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (en) state <= FILL;
                end
                FILL: begin
                    if (!en) state <= IDLE;
                    else if (fill_nxt == FILL_MAX) state <= SCAN;
                end
                SCAN: begin
                    if (!en) state <= IDLE;
                    else if (match && !overlap) state <= FILL;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fsmlog_seq_det.sv
// tb/tb_fsmlog_seq_det.sv - self-checking bench for fsmlog_seq_det
module tb_fsmlog_seq_det;
    localparam int W     = 1;
    localparam int N     = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             in_vld;
    logic [W-1:0]     in_dat;
    logic [N*W-1:0]   pat;
    logic [N-1:0]     pat_mask;
    logic             overlap;
    logic             clr;
    logic             hit;
    logic             flag;
    logic [CNT_W-1:0] hit_cnt;
    logic [1:0]       state_o;

    always #5 clk = ~clk;

    fsmlog_seq_det #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_vld   (in_vld),
        .in_dat   (in_dat),
        .pat      (pat),
        .pat_mask (pat_mask),
        .overlap  (overlap),
        .clr      (clr),
        .hit      (hit),
        .flag     (flag),
        .hit_cnt  (hit_cnt),
        .state_o  (state_o)
    );

    typedef struct {
        bit         en;
        bit         vld;
        logic [W-1:0] dat;
        bit         clr;
        bit         hit;
        logic [1:0] st;
        int         cnt;
        bit         flag;
    } vec_t;

    int    vectors     = 0;
    int    miscompares = 0;
    int    hits        = 0;
    string phase       = "reset";

    // Reference: queue of accepted symbols since the last restart, oldest first.
    logic [W-1:0] mq[$];
    bit           m_hit;
    bit           m_flag;
    int           m_cnt;
    int           m_st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s.%s: got %0d expected %0d", phase, name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_hit  = 0;
        m_flag = 0;
        m_cnt  = 0;
        m_st   = 0;
    endtask

    task automatic model_step();
        bit m;
        m = 0;
        if (en && in_vld) begin
            mq.push_back(in_dat);
            if (mq.size() > N) void'(mq.pop_front());
            if (mq.size() == N) begin
                m = 1;
                for (int k = 0; k < N; k++)
                    if (!pat_mask[k] && (mq[k] !== pat[k*W +: W])) m = 0;
            end
        end
        if (m && !overlap) mq.delete();
        if (!en) mq.delete();
        m_hit = m;
        if (m) m_cnt = clr ? 1 : (m_cnt < CMAX ? m_cnt + 1 : m_cnt);
        else if (clr) m_cnt = 0;
        if (m) m_flag = 1;
        else if (clr) m_flag = 0;
        if (!en) m_st = 0;
        else if (m_st == 0) m_st = 1;
        else m_st = (mq.size() == N) ? 2 : 1;
    endtask

    task automatic check_model();
        chk("hit", 32'(hit), 32'(m_hit));
        chk("flag", 32'(flag), 32'(m_flag));
        chk("hit_cnt", 32'(hit_cnt), 32'(m_cnt));
        chk("state", 32'(state_o), 32'(m_st));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        if (hit === 1'b1) hits++;
        check_model();
    endtask

    task automatic sym(input bit v, input logic [W-1:0] d);
        in_vld = v;
        in_dat = d;
        step();
        in_vld = 0;
    endtask

    task automatic do_reset();
        rst    = 0;
        en     = 0;
        in_vld = 0;
        in_dat = '0;
        clr    = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
        en  = 1;
        hits = 0;
    endtask

    vec_t tbl[8];
    int   exp_c[5];
    logic [W-1:0] strm[7];

    initial begin
        tbl[0] = '{1, 1, 1'b1, 0, 0, 2'd1, 0, 0};
        tbl[1] = '{1, 1, 1'b0, 0, 0, 2'd1, 0, 0};
        tbl[2] = '{1, 1, 1'b1, 0, 0, 2'd1, 0, 0};
        tbl[3] = '{1, 1, 1'b1, 0, 1, 2'd2, 1, 1};
        tbl[4] = '{1, 1, 1'b0, 0, 0, 2'd2, 1, 1};
        tbl[5] = '{1, 1, 1'b1, 0, 0, 2'd2, 1, 1};
        tbl[6] = '{1, 1, 1'b1, 0, 1, 2'd2, 2, 1};
        tbl[7] = '{1, 0, 1'b0, 0, 0, 2'd2, 2, 1};
        exp_c  = '{1, 2, 3, 3, 3};
        strm   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        pat      = 4'b1101;
        pat_mask = 4'b0000;
        overlap  = 1;
        rst = 0; en = 0; in_vld = 0; in_dat = '0; clr = 0;
        model_reset();
        #2;
        chk("hit", 32'(hit), 0);
        chk("flag", 32'(flag), 0);
        chk("hit_cnt", 32'(hit_cnt), 0);
        chk("state", 32'(state_o), 0);
        do_reset();

        phase = "table_overlap";
        for (int i = 0; i < 8; i++) begin
            en = tbl[i].en; in_vld = tbl[i].vld; in_dat = tbl[i].dat; clr = tbl[i].clr;
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("hit[%0d]", i), 32'(hit), 32'(tbl[i].hit));
            chk($sformatf("state[%0d]", i), 32'(state_o), 32'(tbl[i].st));
            chk($sformatf("cnt[%0d]", i), 32'(hit_cnt), 32'(tbl[i].cnt));
            chk($sformatf("flag[%0d]", i), 32'(flag), 32'(tbl[i].flag));
        end
        in_vld = 0;

        phase = "no_overlap";
        overlap = 0;
        do_reset();
        for (int i = 0; i < 7; i++) sym(1, strm[i]);
        chk("hits", 32'(hits), 1);
        chk("end_state", 32'(state_o), 1);
        chk("end_cnt", 32'(hit_cnt), 1);

        phase = "gaps";
        overlap = 1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            sym(1, strm[i]);
            for (int g = $urandom_range(0, 3); g > 0; g--) sym(0, 1'b0);
        end
        sym(0, 1'b0);
        chk("hits", 32'(hits), 2);

        phase = "mask";
        overlap = 0;
        pat_mask = 4'b0010;
        do_reset();
        for (int i = 0; i < 4; i++) sym(1, 1'b1);
        chk("hits", 32'(hits), 1);
        pat_mask = 4'b0000;
        do_reset();
        for (int i = 0; i < 4; i++) sym(1, 1'b1);
        chk("nomask_hits", 32'(hits), 0);

        phase = "saturate";
        overlap = 1;
        pat_mask = 4'b1111;
        do_reset();
        for (int i = 0; i < 3; i++) sym(1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            sym(1, 1'(i));
            chk($sformatf("cnt%0d", i), 32'(hit_cnt), 32'(exp_c[i]));
        end
        clr = 1;
        sym(1, 1'b1);
        clr = 0;
        chk("clr_hit_cnt", 32'(hit_cnt), 1);
        chk("clr_hit_flag", 32'(flag), 1);
        clr = 1;
        sym(0, 1'b0);
        clr = 0;
        chk("clr_cnt", 32'(hit_cnt), 0);

        phase = "async_rst";
        pat_mask = 4'b0000;
        do_reset();
        for (int i = 0; i < 3; i++) sym(1, strm[i]);
        #2;
        rst = 0;
        model_reset();
        #1;
        chk("hit", 32'(hit), 0);
        chk("flag", 32'(flag), 0);
        chk("hit_cnt", 32'(hit_cnt), 0);
        chk("state", 32'(state_o), 0);
        #2;
        rst = 1;
        hits = 0;
        sym(1, strm[3]);
        chk("replay_state", 32'(state_o), 1);
        chk("replay_hits", 32'(hits), 0);

        phase = "en_drop";
        do_reset();
        for (int i = 0; i < 4; i++) sym(1, strm[i]);
        sym(1, 1'b1);
        sym(1, 1'b0);
        en = 0;
        sym(1, 1'b1);
        chk("idle_state", 32'(state_o), 0);
        chk("flag_kept", 32'(flag), 1);
        en = 1;
        hits = 0;
        sym(1, 1'b1);
        chk("restart_state", 32'(state_o), 1);
        sym(1, 1'b1);
        chk("no_stale_hit", 32'(hits), 0);

        phase = "random";
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            en     = ($urandom_range(0, 15) != 0);
            in_vld = ($urandom_range(0, 3) != 0);
            in_dat = W'($urandom);
            clr    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) overlap = ~overlap;
            if ($urandom_range(0, 29) == 0) begin
                pat      = N*W'($urandom);
                pat_mask = N'($urandom & $urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
